// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory bus adapter.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } dmem_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Halves must sit on even addresses, words on multiples of four; the
    // unused size encoding 11 behaves like a word.
    function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] addr_lo);
        logic result;
        case (size)
            SIZE_B:  result = 1'b0;
            SIZE_H:  result = addr_lo[0];
            default: result = |addr_lo;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_bus_adapter_if.sv
// Valid/ready request plus response channel between the adapter and the data bus.
interface dmem_bus_adapter_if;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_we;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_data;
    logic        bus_resp_err;

    modport master (
        output bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata, bus_req_wstrb,
        input  bus_req_ready, bus_resp_valid, bus_resp_data, bus_resp_err
    );

    modport slave (
        input  bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata, bus_req_wstrb,
        output bus_req_ready, bus_resp_valid, bus_resp_data, bus_resp_err
    );

endinterface

// File: rtl/dmem_store_align.sv
// Turns a store size, low address bits and low-justified store data into
// byte strobes and lane-replicated write data.
module dmem_store_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addrLo_i,
    input  logic [31:0] writeData_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o
);

    // Copy the value onto every lane it could land in; the strobes pick the real lanes
    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = writeData_i;
        case (size_i)
            SIZE_B: begin
                wstrb_o = 4'b0001 << addrLo_i;
                wdata_o = {4{writeData_i[7:0]}};
            end
            SIZE_H: begin
                wstrb_o = 4'b0011 << addrLo_i;
                wdata_o = {2{writeData_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = writeData_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_bus_adapter.sv
// Memory-stage to data-bus adapter: issues one bus transaction per aligned
// load/store, stalls the pipeline until it completes and returns the raw word.
module dmem_bus_adapter
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                M_mem_read,
    input  logic                M_mem_write,
    input  logic [1:0]          M_store_control,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                stall,
    output logic                misaligned,
    output logic                bus_err,
    dmem_bus_adapter_if.master  bus
);

    // The counter must also hold TIMEOUT_CYCLES itself, reached when a request
    // is accepted on its very last allowed cycle.
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      readData_q, readData_d;
    logic             err_q, err_d;

    logic             hasRequest;
    logic             isMisaligned;
    logic [3:0]       alignWstrb;
    logic [31:0]      alignWdata;
    logic             stallRaw;
    logic             misalignedRaw;
    logic             reqValidRaw;

    assign hasRequest   = M_mem_read | M_mem_write;
    assign isMisaligned = misaligned_f(M_store_control, address[1:0]);

    dmem_store_align u_store_align (
        .size_i      (M_store_control),
        .addrLo_i    (address[1:0]),
        .writeData_i (write_data),
        .wstrb_o     (alignWstrb),
        .wdata_o     (alignWdata)
    );

    // Next-state, request latch, timeout and response capture for the single outstanding access
    always_comb begin
        state_d       = state_q;
        timeoutCnt_d  = timeoutCnt_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        readData_d    = readData_q;
        err_d         = err_q;
        stallRaw      = 1'b0;
        misalignedRaw = 1'b0;
        reqValidRaw   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hasRequest) begin
                    if (isMisaligned) begin
                        misalignedRaw = 1'b1;
                    end else begin
                        stallRaw     = 1'b1;
                        addr_d       = {address[31:2], 2'b00};
                        we_d         = M_mem_write;
                        wdata_d      = M_mem_write ? alignWdata : 32'h0;
                        wstrb_d      = M_mem_write ? alignWstrb : 4'b0000;
                        timeoutCnt_d = '0;
                        err_d        = 1'b0;
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                stallRaw    = 1'b1;
                reqValidRaw = 1'b1;
                // An acceptance wins over the timeout so the bus never sees a
                // handshake that the adapter then ignores.
                if (bus.bus_req_ready) begin
                    timeoutCnt_d = timeoutCnt_q + CNT_W'(1);
                    state_d      = WAIT_RESP;
                end else if (timeoutCnt_q >= CNT_LAST) begin
                    readData_d = 32'h0;
                    err_d      = 1'b1;
                    state_d    = DONE;
                end else begin
                    timeoutCnt_d = timeoutCnt_q + CNT_W'(1);
                end
            end
            WAIT_RESP: begin
                stallRaw = 1'b1;
                if (bus.bus_resp_valid) begin
                    readData_d = bus.bus_resp_err ? 32'h0 : bus.bus_resp_data;
                    err_d      = bus.bus_resp_err;
                    state_d    = DONE;
                end else if (timeoutCnt_q >= CNT_LAST) begin
                    readData_d = 32'h0;
                    err_d      = 1'b1;
                    state_d    = DONE;
                end else begin
                    timeoutCnt_d = timeoutCnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so an in-flight access is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timeoutCnt_q <= '0;
            addr_q       <= 32'h0;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'b0000;
            readData_q   <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timeoutCnt_q <= timeoutCnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            readData_q   <= readData_d;
            err_q        <= err_d;
        end
    end

    assign stall             = reset & stallRaw;
    assign misaligned        = reset & misalignedRaw;
    assign bus_err           = reset & (state_q == DONE) & err_q;
    assign read_data         = readData_q;
    assign bus.bus_req_valid = reset & reqValidRaw;
    assign bus.bus_req_addr  = addr_q;
    assign bus.bus_req_we    = we_q;
    assign bus.bus_req_wdata = wdata_q;
    assign bus.bus_req_wstrb = wstrb_q;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Directed bench for dmem_bus_adapter: inputs change on the falling edge and
// outputs are sampled 1 time unit later, so each check sees one settled cycle.
module tb_dmem_bus_adapter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mMemRead = 1'b0;
    logic        mMemWrite = 1'b0;
    logic [1:0]  mStoreControl = 2'b00;
    logic [31:0] address = 32'h0;
    logic [31:0] writeData = 32'h0;
    logic [31:0] readData;
    logic        stall;
    logic        misaligned;
    logic        busErr;

    int testsRun = 0;
    int testsFailed = 0;

    dmem_bus_adapter_if busIf();

    dmem_bus_adapter #(.TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .M_mem_read      (mMemRead),
        .M_mem_write     (mMemWrite),
        .M_store_control (mStoreControl),
        .address         (address),
        .write_data      (writeData),
        .read_data       (readData),
        .stall           (stall),
        .misaligned      (misaligned),
        .bus_err         (busErr),
        .bus             (busIf.master)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic idleInputs();
        mMemRead                 = 1'b0;
        mMemWrite                = 1'b0;
        mStoreControl            = 2'b00;
        address                  = 32'h0;
        writeData                = 32'h0;
        busIf.bus_req_ready      = 1'b0;
        busIf.bus_resp_valid     = 1'b0;
        busIf.bus_resp_data      = 32'h0;
        busIf.bus_resp_err       = 1'b0;
    endtask

    task automatic test_reset();
        idleInputs();
        mMemRead      = 1'b1;
        mStoreControl = 2'b10;
        address       = 32'h8000_0104;
        #3 reset = 1'b0;
        #2;
        testsRun++;
        if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        testsRun++;
        if (misaligned !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_misaligned: got %b want 0", misaligned); end
        testsRun++;
        if (busIf.bus_req_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b want 0", busIf.bus_req_valid); end
        testsRun++;
        if (readData !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_read_data: got %h want 0", readData); end
        testsRun++;
        if (busErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_bus_err: got %b want 0", busErr); end
        testsRun++;
        if (busIf.bus_req_addr !== 32'h0 || busIf.bus_req_wstrb !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_req_fields: got addr %h wstrb %b want 0/0000", busIf.bus_req_addr, busIf.bus_req_wstrb);
        end
        @(negedge clk);
        @(negedge clk);
        idleInputs();
        reset = 1'b1;
        #1;
        testsRun++;
        if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL post_reset_idle_stall: got %b want 0", stall); end
    endtask

    task automatic test_word_load();
        int stallCycles = 0;
        @(negedge clk);
        mMemRead = 1'b1; mStoreControl = 2'b10; address = 32'h8000_0104;
        #1;
        if (stall === 1'b1) stallCycles++;
        testsRun++;
        if (busIf.bus_req_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL load_idle_valid: got %b want 0", busIf.bus_req_valid); end
        @(negedge clk);
        busIf.bus_req_ready = 1'b1;
        #1;
        if (stall === 1'b1) stallCycles++;
        testsRun++;
        if (busIf.bus_req_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL load_req_valid: got %b want 1", busIf.bus_req_valid); end
        testsRun++;
        if (busIf.bus_req_addr !== 32'h8000_0104) begin testsFailed++; $display("[TB] FAIL load_req_addr: got %h want 80000104", busIf.bus_req_addr); end
        testsRun++;
        if (busIf.bus_req_wstrb !== 4'b0000 || busIf.bus_req_we !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL load_req_wstrb_we: got %b/%b want 0000/0", busIf.bus_req_wstrb, busIf.bus_req_we);
        end
        @(negedge clk);
        busIf.bus_req_ready = 1'b0;
        busIf.bus_resp_valid = 1'b1; busIf.bus_resp_data = 32'hCAFE_BABE;
        #1;
        if (stall === 1'b1) stallCycles++;
        testsRun++;
        if (busIf.bus_req_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL load_wait_valid: got %b want 0", busIf.bus_req_valid); end
        @(negedge clk);
        busIf.bus_resp_valid = 1'b0; busIf.bus_resp_data = 32'h0;
        mMemRead = 1'b0;
        #1;
        if (stall === 1'b1) stallCycles++;
        testsRun++;
        if (readData !== 32'hCAFE_BABE) begin testsFailed++; $display("[TB] FAIL load_read_data: got %h want cafebabe", readData); end
        testsRun++;
        if (busErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL load_bus_err: got %b want 0", busErr); end
        testsRun++;
        if (stallCycles != 3) begin testsFailed++; $display("[TB] FAIL load_stall_cycles: got %0d want 3", stallCycles); end
        @(negedge clk);
        #1;
        testsRun++;
        if (readData !== 32'hCAFE_BABE) begin testsFailed++; $display("[TB] FAIL load_read_data_hold: got %h want cafebabe", readData); end
    endtask

    task automatic test_store_strobes();
        logic [31:0] vAddr  [5] = '{32'h8000_0003, 32'h8000_0001, 32'h8000_0002, 32'h8000_0008, 32'h8000_000C};
        logic [31:0] vData  [5] = '{32'h1234_56A5, 32'h0000_003C, 32'hBEEF_1234, 32'hDEAD_BEEF, 32'h0102_0304};
        logic [1:0]  vSize  [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [3:0]  eStrb  [5] = '{4'b1000, 4'b0010, 4'b1100, 4'b1111, 4'b1111};
        logic [31:0] eWdata [5] = '{32'hA5A5_A5A5, 32'h3C3C_3C3C, 32'h1234_1234, 32'hDEAD_BEEF, 32'h0102_0304};
        logic [31:0] eAddr  [5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0008, 32'h8000_000C};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mMemWrite = 1'b1; mMemRead = (i == 1);
            address = vAddr[i]; writeData = vData[i]; mStoreControl = vSize[i];
            #1;
            testsRun++;
            if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL store%0d_idle_stall: got %b want 1", i, stall); end
            @(negedge clk);
            busIf.bus_req_ready = 1'b1;
            #1;
            testsRun++;
            if (busIf.bus_req_valid !== 1'b1 || busIf.bus_req_we !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL store%0d_valid_we: got %b/%b want 1/1", i, busIf.bus_req_valid, busIf.bus_req_we);
            end
            testsRun++;
            if (busIf.bus_req_wstrb !== eStrb[i]) begin testsFailed++; $display("[TB] FAIL store%0d_wstrb: got %b want %b", i, busIf.bus_req_wstrb, eStrb[i]); end
            testsRun++;
            if (busIf.bus_req_wdata !== eWdata[i]) begin testsFailed++; $display("[TB] FAIL store%0d_wdata: got %h want %h", i, busIf.bus_req_wdata, eWdata[i]); end
            testsRun++;
            if (busIf.bus_req_addr !== eAddr[i]) begin testsFailed++; $display("[TB] FAIL store%0d_addr: got %h want %h", i, busIf.bus_req_addr, eAddr[i]); end
            @(negedge clk);
            busIf.bus_req_ready = 1'b0;
            busIf.bus_resp_valid = 1'b1; busIf.bus_resp_data = 32'h5555_AAAA;
            #1;
            @(negedge clk);
            busIf.bus_resp_valid = 1'b0; busIf.bus_resp_data = 32'h0;
            mMemWrite = 1'b0; mMemRead = 1'b0;
            #1;
            testsRun++;
            if (stall !== 1'b0 || busErr !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL store%0d_done: got stall %b bus_err %b want 0/0", i, stall, busErr);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] vAddr [3] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003};
        logic [1:0]  vSize [3] = '{2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mMemRead = (i != 2); mMemWrite = (i == 2);
            address = vAddr[i]; mStoreControl = vSize[i]; writeData = 32'hFFFF_FFFF;
            #1;
            testsRun++;
            if (misaligned !== 1'b1) begin testsFailed++; $display("[TB] FAIL misal%0d_flag: got %b want 1", i, misaligned); end
            testsRun++;
            if (stall !== 1'b0 || busIf.bus_req_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL misal%0d_stall_valid: got %b/%b want 0/0", i, stall, busIf.bus_req_valid);
            end
            @(negedge clk);
            mMemRead = 1'b0; mMemWrite = 1'b0;
            #1;
            testsRun++;
            if (misaligned !== 1'b0 || busIf.bus_req_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL misal%0d_after: got misaligned %b valid %b want 0/0", i, misaligned, busIf.bus_req_valid);
            end
        end
    endtask

    task automatic test_err_response();
        @(negedge clk);
        mMemRead = 1'b1; mStoreControl = 2'b10; address = 32'h8000_0040;
        #1;
        testsRun++;
        if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_idle_stall: got %b want 1", stall); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            testsRun++;
            if (busIf.bus_req_valid !== 1'b1 || busIf.bus_req_addr !== 32'h8000_0040 ||
                busIf.bus_req_we !== 1'b0 || busIf.bus_req_wstrb !== 4'b0000) begin
                testsFailed++;
                $display("[TB] FAIL err_hold%0d: got valid %b addr %h we %b wstrb %b want 1/80000040/0/0000",
                         k, busIf.bus_req_valid, busIf.bus_req_addr, busIf.bus_req_we, busIf.bus_req_wstrb);
            end
        end
        @(negedge clk);
        busIf.bus_req_ready = 1'b1;
        #1;
        testsRun++;
        if (busIf.bus_req_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_accept_valid: got %b want 1", busIf.bus_req_valid); end
        @(negedge clk);
        busIf.bus_req_ready = 1'b0;
        busIf.bus_resp_valid = 1'b1; busIf.bus_resp_err = 1'b1; busIf.bus_resp_data = 32'h1234_5678;
        #1;
        testsRun++;
        if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_wait_stall: got %b want 1", stall); end
        @(negedge clk);
        busIf.bus_resp_valid = 1'b0; busIf.bus_resp_err = 1'b0; busIf.bus_resp_data = 32'h0;
        mMemRead = 1'b0;
        #1;
        testsRun++;
        if (busErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_bus_err: got %b want 1", busErr); end
        testsRun++;
        if (readData !== 32'h0) begin testsFailed++; $display("[TB] FAIL err_read_data: got %h want 0", readData); end
        testsRun++;
        if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_done_stall: got %b want 0", stall); end
        @(negedge clk);
        #1;
        testsRun++;
        if (busErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_pulse: got %b want 0", busErr); end
    endtask

    task automatic test_timeout();
        logic [31:0] followData [2] = '{32'h0BAD_F00D, 32'h600D_CAFE};
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            mMemRead = 1'b1; mStoreControl = 2'b10; address = 32'h8000_0080;
            #1;
            testsRun++;
            if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL tmo%0d_idle_stall: got %b want 1", v, stall); end
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                busIf.bus_req_ready = (v == 1) && (k == 0);
                #1;
                testsRun++;
                if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL tmo%0d_stall_c%0d: got %b want 1", v, k, stall); end
                testsRun++;
                if (busIf.bus_req_valid !== ((v == 0) || (k == 0))) begin
                    testsFailed++;
                    $display("[TB] FAIL tmo%0d_valid_c%0d: got %b want %b", v, k, busIf.bus_req_valid, ((v == 0) || (k == 0)));
                end
            end
            @(negedge clk);
            busIf.bus_req_ready = 1'b0;
            mMemRead = 1'b0;
            #1;
            testsRun++;
            if (busErr !== 1'b1 || readData !== 32'h0) begin
                testsFailed++;
                $display("[TB] FAIL tmo%0d_done: got bus_err %b read_data %h want 1/0", v, busErr, readData);
            end
            testsRun++;
            if (busIf.bus_req_valid !== 1'b0 || stall !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL tmo%0d_done_valid_stall: got %b/%b want 0/0", v, busIf.bus_req_valid, stall);
            end
            @(negedge clk);
            mMemRead = 1'b1; mStoreControl = 2'b10; address = 32'h8000_0200;
            #1;
            testsRun++;
            if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL tmo%0d_next_accept: got %b want 1", v, stall); end
            @(negedge clk);
            busIf.bus_req_ready = 1'b1;
            #1;
            @(negedge clk);
            busIf.bus_req_ready = 1'b0;
            busIf.bus_resp_valid = 1'b1; busIf.bus_resp_data = followData[v];
            #1;
            @(negedge clk);
            busIf.bus_resp_valid = 1'b0; busIf.bus_resp_data = 32'h0;
            mMemRead = 1'b0;
            #1;
            testsRun++;
            if (readData !== followData[v] || busErr !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL tmo%0d_next_result: got %h err %b want %h err 0", v, readData, busErr, followData[v]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stallCycles = 0;
        @(negedge clk);
        mMemRead = 1'b1; mStoreControl = 2'b10; address = 32'h8000_0300;
        #1;
        @(negedge clk);
        busIf.bus_req_ready = 1'b1;
        #1;
        @(negedge clk);
        busIf.bus_req_ready = 1'b0;
        #1;
        testsRun++;
        if (stall !== 1'b1 || readData !== 32'h600D_CAFE) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_before: got stall %b read_data %h want 1/600dcafe", stall, readData);
        end
        reset = 1'b0;
        #1;
        testsRun++;
        if (busIf.bus_req_valid !== 1'b0 || stall !== 1'b0 || readData !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_cleared: got valid %b stall %b read_data %h want 0/0/0", busIf.bus_req_valid, stall, readData);
        end
        @(negedge clk);
        mMemRead = 1'b0;
        reset = 1'b1;
        #1;
        testsRun++;
        if (stall !== 1'b0 || busIf.bus_req_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_idle: got stall %b valid %b want 0/0", stall, busIf.bus_req_valid);
        end
        @(negedge clk);
        mMemRead = 1'b1; mStoreControl = 2'b10; address = 32'h8000_0304;
        #1;
        if (stall === 1'b1) stallCycles++;
        @(negedge clk);
        busIf.bus_req_ready = 1'b1;
        #1;
        if (stall === 1'b1) stallCycles++;
        testsRun++;
        if (busIf.bus_req_addr !== 32'h8000_0304) begin testsFailed++; $display("[TB] FAIL rstmid_new_addr: got %h want 80000304", busIf.bus_req_addr); end
        @(negedge clk);
        busIf.bus_req_ready = 1'b0;
        busIf.bus_resp_valid = 1'b1; busIf.bus_resp_data = 32'h1357_2468;
        #1;
        if (stall === 1'b1) stallCycles++;
        @(negedge clk);
        busIf.bus_resp_valid = 1'b0; busIf.bus_resp_data = 32'h0;
        mMemRead = 1'b0;
        #1;
        if (stall === 1'b1) stallCycles++;
        testsRun++;
        if (readData !== 32'h1357_2468) begin testsFailed++; $display("[TB] FAIL rstmid_new_data: got %h want 13572468", readData); end
        testsRun++;
        if (stallCycles != 3) begin testsFailed++; $display("[TB] FAIL rstmid_new_stall_cycles: got %0d want 3", stallCycles); end
    endtask

    // Scenario sequence, then the one summary line
    initial begin
        test_reset();
        test_word_load();
        test_store_strobes();
        test_misaligned();
        test_err_response();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
